// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives the J/K inputs of an external JK flip-flop bank to
// perform LOAD/SET/CLEAR/TOGGLE commands, reads the bank back, re-drives
// idempotent ops on mismatch, and reports the final readback with an error flag.
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_CHECK = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    state_t           state, state_nxt;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] exp_r;
    logic [RW-1:0]    retry_cnt;
    logic             err_flag;

    op_t              drv_op;
    logic [WIDTH-1:0] drv_data;
    logic [WIDTH-1:0] drv_j, drv_k;
    logic [WIDTH-1:0] exp_nxt;
    logic             accept;
    logic             mismatch;
    logic             can_retry;

    assign accept    = cmd_valid && (state == S_IDLE);
    assign mismatch  = (q_fb != exp_r);
    assign can_retry = (op_r != OP_TOGGLE) && (retry_cnt < MAX_RETRY_C);

    // Expected bank value computed from the q_fb snapshot taken at accept.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        exp_nxt = cmd_data;
        case (op_t'(cmd_op))
            OP_LOAD:   exp_nxt = cmd_data;
            OP_SET:    exp_nxt = q_fb | cmd_data;
            OP_CLEAR:  exp_nxt = q_fb & ~cmd_data;
            OP_TOGGLE: exp_nxt = q_fb ^ cmd_data;
            default:   exp_nxt = cmd_data;
        endcase
    end

    // J/K pattern for the op about to be driven: the incoming command on the
    // accept edge, otherwise the latched command (retries reuse the same pattern).
    always_comb begin
        drv_op   = (state == S_IDLE) ? op_t'(cmd_op) : op_r;
        drv_data = (state == S_IDLE) ? cmd_data : data_r;
        drv_j    = '0;
        drv_k    = '0;
        case (drv_op)
            OP_LOAD:   begin drv_j = drv_data; drv_k = ~drv_data; end
            OP_SET:    begin drv_j = drv_data; drv_k = '0;        end
            OP_CLEAR:  begin drv_j = '0;       drv_k = drv_data;  end
            OP_TOGGLE: begin drv_j = drv_data; drv_k = drv_data;  end
            default:   begin drv_j = '0;       drv_k = '0;        end
        endcase
    end

    // Next-state logic: one DRIVE cycle, one CHECK cycle, optional retry, then RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_DRIVE;
            S_DRIVE: state_nxt = S_CHECK;
            S_CHECK: state_nxt = (mismatch && can_retry) ? S_DRIVE : S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Command latch, retry counter, error flag and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r      <= OP_LOAD;
            data_r    <= '0;
            exp_r     <= '0;
            retry_cnt <= '0;
            err_flag  <= 1'b0;
            result    <= '0;
        end else begin
            if (accept) begin
                op_r      <= op_t'(cmd_op);
                data_r    <= cmd_data;
                exp_r     <= exp_nxt;
                retry_cnt <= '0;
                err_flag  <= 1'b0;
            end
            if (state == S_CHECK) begin
                if (mismatch && can_retry) begin
                    retry_cnt <= retry_cnt + RW'(1);
                end else begin
                    result   <= q_fb;
                    err_flag <= mismatch;
                end
            end
        end
    end

    // Registered J/K: non-zero only during DRIVE so the bank otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j <= '0;
            k <= '0;
        end else if (state_nxt == S_DRIVE) begin
            j <= drv_j;
            k <= drv_k;
        end else begin
            j <= '0;
            k <= '0;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_RESP);
    assign err       = (state == S_RESP) && err_flag;

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed commands against a behavioural JK bank model
// (with an optional stuck-at-0 bit); expected responses go into a queue and a
// monitor compares them whenever the DUT presents done.
module tb_jk_bank_driver;

    localparam int W = 4;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_SET = 2'b01, OP_CLEAR = 2'b10, OP_TOGGLE = 2'b11;

    typedef struct {
        logic [W-1:0] exp_j;
        logic [W-1:0] exp_k;
        logic [W-1:0] res;
        logic         e;
        int           lat;
        int           drives;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] j, k, q_fb;
    logic         busy, done, err;
    logic [W-1:0] result;

    logic [W-1:0] bank_q;
    logic [W-1:0] stuck0;
    int           cyc = 0;
    int           n_total = 0;
    int           n_pass = 0;
    int           drive_cnt = 0;
    exp_t         exp_q[$];

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External JK bank: Q+ = J&~Q | ~K&Q, bits in stuck0 forced low.
    always @(posedge clk or posedge rst) begin
        if (rst) bank_q <= '0;
        else     bank_q <= ((j & ~bank_q) | (~k & bank_q)) & ~stuck0;
    end
    assign q_fb = bank_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    endtask

    function automatic exp_t mk(input logic [W-1:0] ej, input logic [W-1:0] ek,
                                input logic [W-1:0] res, input logic e,
                                input int lat, input int drives);
        exp_t x;
        x.exp_j = ej; x.exp_k = ek; x.res = res; x.e = e;
        x.lat = lat; x.drives = drives; x.acc_cyc = 0;
        return x;
    endfunction

    // Offer a command (called on a falling edge); returns the accept cycle.
    task automatic send(input logic [1:0] op, input logic [W-1:0] data, input exp_t e,
                        input bit hold, output int acc);
        int n = 0;
        cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!cmd_ready) begin
            check("accept_timeout", {31'b0, cmd_ready}, 32'd1);
        end else begin
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((!cmd_ready || exp_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'b0, cmd_ready}, 32'd1);
    endtask

    // Monitor: checks every drive cycle and every completion against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                drive_cnt = 0;
            end else begin
                if (err) check("err_only_with_done", {31'b0, done}, 32'd1);
                if ((j | k) != '0) begin
                    drive_cnt++;
                    if (exp_q.size() == 0) begin
                        check("drive_without_cmd", exp_q.size(), 32'd1);
                    end else begin
                        check("drive_j", {28'b0, j}, {28'b0, exp_q[0].exp_j});
                        check("drive_k", {28'b0, k}, {28'b0, exp_q[0].exp_k});
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("done_without_cmd", exp_q.size(), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("result",  {28'b0, result}, {28'b0, e.res});
                        check("err",     {31'b0, err}, {31'b0, e.e});
                        check("latency", cyc - e.acc_cyc, e.lat);
                        check("drives",  drive_cnt, e.drives);
                    end
                    drive_cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; stuck0 = '0;
        repeat (2) @(negedge clk);
        check("rst_j",         {28'b0, j}, 32'd0);
        check("rst_k",         {28'b0, k}, 32'd0);
        check("rst_busy",      {31'b0, busy}, 32'd0);
        check("rst_done",      {31'b0, done}, 32'd0);
        check("rst_err",       {31'b0, err}, 32'd0);
        check("rst_result",    {28'b0, result}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // LOAD 1010 into an empty bank.
        send(OP_LOAD, 4'b1010, mk(4'b1010, 4'b0101, 4'b1010, 1'b0, 3, 1), 1'b0, a0);
        // TOGGLE 0110: 1010 -> 1100.
        send(OP_TOGGLE, 4'b0110, mk(4'b0110, 4'b0110, 4'b1100, 1'b0, 3, 1), 1'b0, a0);
        wait_idle();

        // SET 0001 then CLEAR 1000 with cmd_valid held: 1100 -> 1101 -> 0101.
        send(OP_SET,   4'b0001, mk(4'b0001, 4'b0000, 4'b1101, 1'b0, 3, 1), 1'b1, a1);
        send(OP_CLEAR, 4'b1000, mk(4'b0000, 4'b1000, 4'b0101, 1'b0, 3, 1), 1'b0, a2);
        check("accept_spacing", a2 - a1, 32'd4);

        // Zero mask: no drive, bank unchanged.
        send(OP_SET,    4'b0000, mk(4'b0000, 4'b0000, 4'b0101, 1'b0, 3, 0), 1'b0, a0);
        send(OP_TOGGLE, 4'b0000, mk(4'b0000, 4'b0000, 4'b0101, 1'b0, 3, 0), 1'b0, a0);
        wait_idle();

        // Bit0 stuck at 0: LOAD retries twice, TOGGLE never retries.
        stuck0 = 4'b0001;
        send(OP_LOAD,   4'b1111, mk(4'b1111, 4'b0000, 4'b1110, 1'b1, 7, 3), 1'b0, a0);
        send(OP_TOGGLE, 4'b0011, mk(4'b0011, 4'b0011, 4'b1100, 1'b1, 3, 1), 1'b0, a0);
        wait_idle();
        stuck0 = 4'b0000;

        // CLEAR 0100: 1100 -> 1000.
        send(OP_CLEAR, 4'b0100, mk(4'b0000, 4'b0100, 4'b1000, 1'b0, 3, 1), 1'b0, a0);
        wait_idle();

        // Reset while in CHECK: command discarded, no done/err.
        send(OP_LOAD, 4'b0011, mk(4'b0011, 4'b1100, 4'b0011, 1'b0, 3, 1), 1'b0, a0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_j",    {28'b0, j}, 32'd0);
        check("abort_k",    {28'b0, k}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_err",  {31'b0, err}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (4) @(negedge clk);

        // Recovery: bank was reset to 0.
        send(OP_LOAD, 4'b0101, mk(4'b0101, 4'b1010, 4'b0101, 1'b0, 3, 1), 1'b0, a0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jk_bank_driver.md
JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 Parameter WIDTH, default 4, number of external JK flip-flops driven.
REQ-002 Parameter MAX_RETRY, default 2, maximum re-drives after a failed readback on idempotent ops.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  block can accept a command; high only in IDLE.
REQ-007 cmd_op  input  2  00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE.
REQ-008 cmd_data  input  WIDTH  LOAD: target value; other ops: bit mask.
REQ-009 j  output  WIDTH  J inputs of external flip-flop bank, registered.
REQ-010 k  output  WIDTH  K inputs of external flip-flop bank, registered.
REQ-011 q_fb  input  WIDTH  Q outputs of external bank; the bank shares clk and rst.
REQ-012 busy  output  1  command in progress (state not IDLE).
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle pulse coincident with done; readback mismatch after final attempt.
REQ-015 result  output  WIDTH  q_fb captured at completion; held until next completion.

Function
REQ-016 States IDLE, DRIVE, CHECK, RESP; IDLE after reset.
REQ-017 Accept when cmd_valid and cmd_ready at a rising edge; latch op and data, snapshot q_fb into snap, compute expected, go to DRIVE, clear retry count.
REQ-018 Expected value: LOAD = data; SET = snap | data; CLEAR = snap & ~data; TOGGLE = snap ^ data.
REQ-019 In DRIVE, drive for exactly one cycle: LOAD j = data, k = ~data; SET j = data, k = 0; CLEAR j = 0, k = data; TOGGLE j = data, k = data.
REQ-020 j and k are all-zero in every state except DRIVE, so the bank holds.
REQ-021 DRIVE always moves to CHECK; the bank updates on the edge ending DRIVE.
REQ-022 CHECK compares q_fb to expected; on match, go to RESP with err flag clear.
REQ-023 On mismatch with op LOAD, SET or CLEAR and retry count < MAX_RETRY: increment retry count, return to DRIVE with the same j/k.
REQ-024 On mismatch with op TOGGLE, or with retry count = MAX_RETRY: go to RESP with err flag set; TOGGLE is never retried.
REQ-025 Entering RESP registers result = q_fb sampled in CHECK.
REQ-026 In RESP: done = 1 and err = flag for one cycle, then return to IDLE.
REQ-027 Latency without retry: accept edge to done high is 3 cycles (DRIVE, CHECK, RESP); each retry adds 2 cycles.
REQ-028 cmd_valid is ignored while busy; no command queueing.
REQ-029 A command may be accepted on the edge that leaves RESP? No: cmd_ready rises in the cycle after RESP (IDLE), giving a minimum spacing of 4 cycles between accepts.
REQ-030 Zero mask on SET, CLEAR or TOGGLE is legal: j = k = 0, expected = snap, completes without err.

Reset
REQ-031 While rst is high, immediately: state IDLE, j = 0, k = 0, busy = 0, done = 0, err = 0, result = 0, retry count = 0.
REQ-032 cmd_ready = 1 in IDLE, including immediately after reset.
REQ-033 rst mid-command aborts with no done or err pulse; the in-flight command is discarded.

Verification
REQ-034 Reset, then LOAD data = 4'b1010 with bank at 0 -> one cycle of j = 1010, k = 0101; done 3 cycles after accept; err = 0; result = 1010.
REQ-035 Bank = 1010, TOGGLE mask = 0110 -> j = k = 0110 for one cycle; result = 1100; err = 0.
REQ-036 Bank = 1100, SET 0001 then CLEAR 1000 back-to-back with cmd_valid held -> accepts 4 cycles apart; results 1101, then 0101.
REQ-037 LOAD 1111 with bank model forcing bit0 stuck at 0 -> DRIVE issued 3 times total; done 7 cycles after accept; err = 1; result = 1110.
REQ-038 TOGGLE with stuck-bit model -> exactly one DRIVE, no retry; done at 3 cycles with err = 1.
REQ-039 Assert rst during CHECK -> j = k = 0, busy = 0 at once; no done or err pulse; cmd_ready = 1 after release.
